// File: rtl/ncpu32k_wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// ncpu32k_wb_arb_pkg
//
// Shared definitions for the writeback arbiter that sits in front of the
// register file's single write port.
//
// Contents:
//   calc_gw()            width of a grant index for n requesters (min 1)
//   WB_N_REQ_MIN/MAX     legal range of the requester count
//   WB_REQ_*             requester slot assignment on the writeback buses
//
// Build option seen by the users of this package:
//   NCPU_WB_ARB_FIXED_PRIO_EN  fixed lowest-index-first priority instead of
//                              round-robin (see ncpu32k_wb_arbiter)
// ---------------------------------------------------------------------------
package ncpu32k_wb_arb_pkg;

    // Legal range of requester counts for the arbiter.
    localparam int WB_N_REQ_MIN = 2;
    localparam int WB_N_REQ_MAX = 8;

    // Slot assignment of the execute units on the arbiter inputs.
    localparam int WB_REQ_ALU = 0;
    localparam int WB_REQ_LSU = 1;
    localparam int WB_REQ_MUL = 2;
    localparam int WB_REQ_SPR = 3;

    // Number of bits needed to hold an index 0..n-1. The result is at least
    // 1, so that a two-requester arbiter still has a real index signal.
    function automatic int calc_gw(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ncpu32k_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// ncpu32k_wb_arbiter_if
//
// Bundles the requester side and the register-file side of the writeback
// arbiter.
//
// Parameters: N_REQ requesters, AW address bits, DW data bits; GW is derived.
//
// Signals:
//   req_valid  [N_REQ]     per-requester write request
//   req_addr   [N_REQ*AW]  packed addresses, requester i at [i*AW +: AW]
//   req_dat    [N_REQ*DW]  packed data, requester i at [i*DW +: DW]
//   req_ready  [N_REQ]     one-hot accept
//   rf_we, rf_waddr, rf_wdat  register-file write port
//   rf_ready               register file consumes the write this cycle
//   grant_id   [GW]        requester held in the output stage
//   busy                   output stage occupied
//
// Modports:
//   slave   the arbiter itself
//   master  the surrounding pipeline (requesters + register file)
// ---------------------------------------------------------------------------
interface ncpu32k_wb_arbiter_if
    import ncpu32k_wb_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int GW = calc_gw(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_dat;
    logic [N_REQ-1:0]    req_ready;
    logic                rf_we;
    logic [AW-1:0]       rf_waddr;
    logic [DW-1:0]       rf_wdat;
    logic                rf_ready;
    logic [GW-1:0]       grant_id;
    logic                busy;

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_dat,
        input  rf_ready,
        output req_ready,
        output rf_we,
        output rf_waddr,
        output rf_wdat,
        output grant_id,
        output busy
    );

    modport master (
        output req_valid,
        output req_addr,
        output req_dat,
        output rf_ready,
        input  req_ready,
        input  rf_we,
        input  rf_waddr,
        input  rf_wdat,
        input  grant_id,
        input  busy
    );

endinterface

// File: rtl/ncpu32k_rr_pick.sv
// ---------------------------------------------------------------------------
// ncpu32k_rr_pick
//
// Combinational rotate-priority picker. Scans the valid vector upward from
// the start index, wrapping modulo N_REQ, and reports the first set bit.
//
// Ports:
//   valid_i  [N_REQ]  candidate requests
//   start_i  [GW]     index with highest priority this cycle (< N_REQ)
//   gnt_o    [N_REQ]  one-hot grant, all zero when nothing is valid
//   idx_o    [GW]     index of the granted bit, 0 when nothing is valid
//   any_o             at least one candidate was valid
// ---------------------------------------------------------------------------
module ncpu32k_rr_pick
    import ncpu32k_wb_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int GW    = calc_gw(N_REQ)
)(
    input  logic [N_REQ-1:0] valid_i,
    input  logic [GW-1:0]    start_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [GW-1:0]    idx_o,
    output logic             any_o
);

    // start + k folded back into 0..N_REQ-1; both operands are below N_REQ
    // so a single subtraction is enough.
    function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] s, input int k);
        int j;
        j = int'(s) + k;
        if (j >= N_REQ) begin
            j = j - N_REQ;
        end
        return GW'(j);
    endfunction

    logic [GW-1:0] cand;

    // Walk the offsets from the farthest back to the nearest, so the last
    // hit written is the one closest to the start index and wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = wrap_idx(start_i, k);
            if (valid_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ncpu32k_wb_arbiter.sv
// ---------------------------------------------------------------------------
// ncpu32k_wb_arbiter
//
// Shares the register file's single write port among N_REQ writeback
// requesters. One request is granted per cycle into a one-entry registered
// output stage, which drives the write port and holds while the register
// file back-pressures. Writes to r0 are accepted and occupy the stage but
// never raise rf_we.
//
// Ports:
//   clk   clock, all state on the rising edge
//   rst   asynchronous active-high reset
//   bus   ncpu32k_wb_arbiter_if.slave (requester handshakes + write port)
//
// Build option:
//   NCPU_WB_ARB_FIXED_PRIO_EN  defined: the scan always starts at index 0
//                              (lowest index wins, no rotating pointer).
//                              Undefined (default): round-robin.
// ---------------------------------------------------------------------------
module ncpu32k_wb_arbiter
    import ncpu32k_wb_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
)(
    input  logic                clk,
    input  logic                rst,
    ncpu32k_wb_arbiter_if.slave bus
);

    localparam int GW = calc_gw(N_REQ);

    logic              out_valid_q, out_valid_d;
    logic [AW-1:0]     out_addr_q,  out_addr_d;
    logic [DW-1:0]     out_dat_q,   out_dat_d;
    logic [GW-1:0]     grant_id_q,  grant_id_d;

    logic              accept;
    logic              handshake;
    logic [N_REQ-1:0]  pick_gnt;
    logic [GW-1:0]     pick_idx;
    logic              pick_any;
    logic [GW-1:0]     scan_start;

    logic [AW-1:0]     slot_addr [N_REQ];
    logic [DW-1:0]     slot_dat  [N_REQ];

    // Split the packed request buses into per-slot arrays so the payload
    // mux below can index by the grant index directly.
    for (genvar g = 0; g < N_REQ; g++) begin : g_slot
        assign slot_addr[g] = bus.req_addr[g*AW +: AW];
        assign slot_dat[g]  = bus.req_dat[g*DW +: DW];
    end

    // The stage can take a new entry when it is empty or when its current
    // entry retires on this same edge, so there is no bubble between writes.
    assign accept    = !out_valid_q || bus.rf_ready;
    assign handshake = accept && pick_any;

`ifdef NCPU_WB_ARB_FIXED_PRIO_EN
    assign scan_start = '0;
`else
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;

    assign scan_start = rr_ptr_q;

    // After a grant the requester just served drops to lowest priority.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (handshake) begin
            if (pick_idx == GW'(N_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = pick_idx + GW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    ncpu32k_rr_pick #(
        .N_REQ (N_REQ),
        .GW    (GW)
    ) u_pick (
        .valid_i (bus.req_valid),
        .start_i (scan_start),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Only the picked requester sees ready, and only when the stage can
    // actually take it; a full stage under back-pressure accepts nobody.
    assign bus.req_ready = accept ? pick_gnt : '0;

    // Output stage next state: load on handshake, drain when the register
    // file consumes the entry and nobody is waiting, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_dat_d   = out_dat_q;
        grant_id_d  = grant_id_q;
        if (accept) begin
            if (pick_any) begin
                out_valid_d = 1'b1;
                out_addr_d  = slot_addr[pick_idx];
                out_dat_d   = slot_dat[pick_idx];
                grant_id_d  = pick_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Reset throws away any held entry, so it is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_dat_q   <= '0;
            grant_id_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_dat_q   <= out_dat_d;
            grant_id_q  <= grant_id_d;
        end
    end

    // r0 is hardwired to zero: an entry addressed to it is consumed like any
    // other but never reaches the write enable.
    assign bus.rf_we    = out_valid_q && (out_addr_q != '0);
    assign bus.rf_waddr = out_addr_q;
    assign bus.rf_wdat  = out_dat_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = out_valid_q;

endmodule

// File: tb/tb_ncpu32k_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ncpu32k_wb_arbiter
//
// Self-checking bench for ncpu32k_wb_arbiter with four requesters. A small
// reference model predicts req_ready and the output stage each cycle; every
// predicted handshake pushes the expected write into a queue that is popped
// when the DUT's output stage shows it. A vector table exercises single
// writes, round-robin rotation and back-pressure; hand-written sequences
// cover held back-pressure, r0 writes and reset in mid-operation.
// ---------------------------------------------------------------------------
module tb_ncpu32k_wb_arbiter;
    import ncpu32k_wb_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int GW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ncpu32k_wb_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();

    ncpu32k_wb_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [N-1:0] valid;
        logic         rf_rdy;
        logic [N-1:0] exp_rr;
        logic [N-1:0] exp_fix;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        logic [GW-1:0] id;
    } wr_t;

    vec_t          vecs [16];
    wr_t           sb [$];
    int            checks = 0;
    int            errors = 0;

    logic [AW-1:0] cur_addr [N];
    logic [DW-1:0] cur_dat  [N];

    // Reference model state
    logic          m_ov;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_dat;
    logic [GW-1:0] m_gid;
    int            m_ptr;
    logic          m_loaded;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] modelReady(input logic [N-1:0] v, input logic rr);
        logic [N-1:0] r;
        int start;
        r = '0;
        if (m_ov && !rr) return r;
`ifdef NCPU_WB_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (v[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic modelReset();
        m_ov     = 1'b0;
        m_addr   = '0;
        m_dat    = '0;
        m_gid    = '0;
        m_ptr    = 0;
        m_loaded = 1'b0;
        sb.delete();
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic rr);
        bus.req_valid = v;
        bus.rf_ready  = rr;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW] = cur_addr[i];
            bus.req_dat[i*DW +: DW]  = cur_dat[i];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [N-1:0] v, input logic rr);
        wr_t e;
        checkVal({tag, " req_ready"}, 64'(bus.req_ready), 64'(modelReady(v, rr)));
        if (m_loaded) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL %s scoreboard: got empty queue expected an entry", tag);
            end else begin
                e = sb.pop_front();
                checkVal({tag, " sb_waddr"}, 64'(bus.rf_waddr), 64'(e.addr));
                checkVal({tag, " sb_wdat"}, 64'(bus.rf_wdat), 64'(e.dat));
                checkVal({tag, " sb_gid"}, 64'(bus.grant_id), 64'(e.id));
            end
        end
        checkVal({tag, " busy"}, 64'(bus.busy), 64'(m_ov));
        checkVal({tag, " rf_we"}, 64'(bus.rf_we), 64'(m_ov && (m_addr != '0)));
        checkVal({tag, " hold_waddr"}, 64'(bus.rf_waddr), 64'(m_addr));
        checkVal({tag, " hold_wdat"}, 64'(bus.rf_wdat), 64'(m_dat));
        checkVal({tag, " hold_gid"}, 64'(bus.grant_id), 64'(m_gid));
    endtask

    // One clock: drive at edge+1, check at edge+4, advance model at edge.
    task automatic step(input string tag, input logic [N-1:0] v, input logic rr,
                        input logic [N-1:0] texp);
        logic [N-1:0] exp;
        int gi;
        wr_t w;
        applyStimulus(v, rr);
        #3;
        checkOutput(tag, v, rr);
        checkVal({tag, " table_ready"}, 64'(bus.req_ready), 64'(texp));
        exp = modelReady(v, rr);
        gi  = -1;
        for (int i = 0; i < N; i++) begin
            if (exp[i]) gi = i;
        end
        if (gi >= 0) begin
            w.addr = cur_addr[gi];
            w.dat  = cur_dat[gi];
            w.id   = GW'(gi);
            sb.push_back(w);
        end
        @(posedge clk);
        m_loaded = 1'b0;
        if (!m_ov || rr) begin
            if (gi >= 0) begin
                m_ov     = 1'b1;
                m_addr   = cur_addr[gi];
                m_dat    = cur_dat[gi];
                m_gid    = GW'(gi);
                m_ptr    = (gi + 1) % N;
                m_loaded = 1'b1;
                cur_addr[gi] = AW'($urandom_range(31, 1));
                cur_dat[gi]  = $urandom;
            end else begin
                m_ov = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        logic [N-1:0] texp;

        vecs[0]  = '{4'b0010, 1'b1, 4'b0010, 4'b0010};
        vecs[1]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 4'b0001};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 4'b0001};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 4'b0001};
        vecs[6]  = '{4'b1111, 1'b1, 4'b0100, 4'b0001};
        vecs[7]  = '{4'b1111, 1'b0, 4'b0000, 4'b0000};
        vecs[8]  = '{4'b1111, 1'b0, 4'b0000, 4'b0000};
        vecs[9]  = '{4'b1111, 1'b1, 4'b1000, 4'b0001};
        vecs[10] = '{4'b0101, 1'b1, 4'b0001, 4'b0001};
        vecs[11] = '{4'b0101, 1'b1, 4'b0100, 4'b0001};
        vecs[12] = '{4'b0101, 1'b1, 4'b0001, 4'b0001};
        vecs[13] = '{4'b1000, 1'b1, 4'b1000, 4'b1000};
        vecs[14] = '{4'b0000, 1'b1, 4'b0000, 4'b0000};
        vecs[15] = '{4'b0000, 1'b0, 4'b0000, 4'b0000};

        for (int i = 0; i < N; i++) begin
            cur_addr[i] = AW'($urandom_range(31, 1));
            cur_dat[i]  = $urandom;
        end
        modelReset();
        applyStimulus('0, 1'b1);

        // Reset held for three cycles with no requests
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkVal("rst rf_we", 64'(bus.rf_we), 64'd0);
            checkVal("rst busy", 64'(bus.busy), 64'd0);
            checkVal("rst grant_id", 64'(bus.grant_id), 64'd0);
            checkVal("rst req_ready", 64'(bus.req_ready), 64'd0);
            checkVal("rst rf_waddr", 64'(bus.rf_waddr), 64'd0);
            checkVal("rst rf_wdat", 64'(bus.rf_wdat), 64'd0);
        end
        rst = 1'b0;
        step("idle0", 4'b0000, 1'b1, 4'b0000);
        step("idle1", 4'b0000, 1'b0, 4'b0000);

        // Table: single write first, then rotation and back-pressure
        cur_addr[1] = 5'd7;
        cur_dat[1]  = 32'hDEADBEEF;
        for (int i = 0; i < 16; i++) begin
`ifdef NCPU_WB_ARB_FIXED_PRIO_EN
            texp = vecs[i].exp_fix;
`else
            texp = vecs[i].exp_rr;
`endif
            step($sformatf("vec%0d", i), vecs[i].valid, vecs[i].rf_rdy, texp);
            if (i == 0) begin
                checkVal("single rf_we", 64'(bus.rf_we), 64'd1);
                checkVal("single rf_waddr", 64'(bus.rf_waddr), 64'd7);
                checkVal("single rf_wdat", 64'(bus.rf_wdat), 64'hDEADBEEF);
                checkVal("single grant_id", 64'(bus.grant_id), 64'd1);
            end
        end

        // Back-pressure held for four cycles with requester 2 waiting
        cur_addr[0] = 5'd5;
        cur_dat[0]  = 32'hA5A5_0005;
        step("bp_fill", 4'b0001, 1'b1, 4'b0001);
        cur_addr[2] = 5'd11;
        cur_dat[2]  = 32'h0B0B_1111;
        repeat (4) begin
            step("bp_hold", 4'b0100, 1'b0, 4'b0000);
            checkVal("bp_hold rf_waddr", 64'(bus.rf_waddr), 64'd5);
            checkVal("bp_hold rf_wdat", 64'(bus.rf_wdat), 64'hA5A5_0005);
        end
        step("bp_release", 4'b0100, 1'b1, 4'b0100);
        #2;
        checkVal("bp_after rf_waddr", 64'(bus.rf_waddr), 64'd11);
        checkVal("bp_after rf_wdat", 64'(bus.rf_wdat), 64'h0B0B_1111);
        checkVal("bp_after grant_id", 64'(bus.grant_id), 64'd2);
        step("bp_drain", 4'b0000, 1'b1, 4'b0000);

        // Write to r0: accepted, occupies the stage, no write enable
        cur_addr[0] = 5'd0;
        cur_dat[0]  = 32'h12345678;
        step("r0_req", 4'b0001, 1'b1, 4'b0001);
        #1;
        checkVal("r0 busy", 64'(bus.busy), 64'd1);
        checkVal("r0 rf_we", 64'(bus.rf_we), 64'd0);
        step("r0_drain", 4'b0000, 1'b1, 4'b0000);
        step("r0_idle", 4'b0000, 1'b1, 4'b0000);

        // Reset asserted while an entry for r9 is held
        cur_addr[1] = 5'd9;
        cur_dat[1]  = 32'h0909_0909;
        step("mid_load", 4'b0010, 1'b1, 4'b0010);
        applyStimulus(4'b0000, 1'b0);
        #2;
        checkVal("mid before rf_we", 64'(bus.rf_we), 64'd1);
        checkVal("mid before rf_waddr", 64'(bus.rf_waddr), 64'd9);
        #1;
        rst = 1'b1;
        #1;
        checkVal("mid rst rf_we", 64'(bus.rf_we), 64'd0);
        checkVal("mid rst busy", 64'(bus.busy), 64'd0);
        checkVal("mid rst rf_waddr", 64'(bus.rf_waddr), 64'd0);
        checkVal("mid rst grant_id", 64'(bus.grant_id), 64'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst_all", 4'b1111, 1'b1, 4'b0001);
        step("post_rst_next", 4'b0000, 1'b1, 4'b0000);
        step("post_rst_idle", 4'b0000, 1'b1, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
